dp_ram_fifo: RTL

DP_RAM_FIFO -- requirements
Module: dp_ram_fifo

---
 rtl/dp_ram_fifo_pkg.sv | 11 +
 rtl/simple_dual_port_ram.sv | 39 +++
 rtl/dp_ram_fifo.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dp_ram_fifo_pkg.sv
// Shared memory constants for the dual-port-RAM FIFO: status FSM encodings.
package dp_ram_fifo_pkg;

    // Occupancy status tracked by the FIFO status FSM.
    typedef enum logic [1:0] {
        StateEmpty   = 2'd0,
        StatePartial = 2'd1,
        StateFull    = 2'd2
    } fifoState_t;

endpackage

// File: rtl/simple_dual_port_ram.sv
// Two-port RAM: port 0 write-only, port 1 write plus registered read.
// INDEX_BITS sets the number of physical words; addresses are zero-extended or
// truncated to that index width.
module simple_dual_port_ram #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned INDEX_BITS    = 4
) (
    input  logic                     clock,
    input  logic                     writeEnable_0,
    input  logic [ADDRESS_WIDTH-1:0] address_0,
    input  logic [DATA_WIDTH-1:0]    writeData_0,
    input  logic                     writeEnable_1,
    input  logic [ADDRESS_WIDTH-1:0] address_1,
    input  logic [DATA_WIDTH-1:0]    writeData_1,
    output logic [DATA_WIDTH-1:0]    readData_1
);

    localparam int unsigned WORDS = 1 << INDEX_BITS;

    logic [DATA_WIDTH-1:0] memory [WORDS];
    logic [INDEX_BITS-1:0] index0;
    logic [INDEX_BITS-1:0] index1;

    assign index0 = INDEX_BITS'(address_0);
    assign index1 = INDEX_BITS'(address_1);

    // Writes on both ports and a registered read on port 1; no reset on storage.
    always_ff @(posedge clock) begin
        if (writeEnable_0) begin
            memory[index0] <= writeData_0;
        end
        if (writeEnable_1) begin
            memory[index1] <= writeData_1;
        end
        readData_1 <= memory[index1];
    end

endmodule

// File: rtl/dp_ram_fifo.sv
// Synchronous FIFO on a simple dual-port RAM with one-cycle pop latency.
// Optional: define DP_RAM_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module dp_ram_fifo
    import dp_ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned INDEX_BITS    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    output logic                     full,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic                     pop_valid,
    output logic                     empty,
    output logic [ADDRESS_WIDTH:0]   count
`ifdef DP_RAM_FIFO_ERR_FLAGS_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam logic [ADDRESS_WIDTH:0] PTR_ONE   = (ADDRESS_WIDTH+1)'(1);
    localparam logic [ADDRESS_WIDTH:0] LAST_FREE = (ADDRESS_WIDTH+1)'((1 << ADDRESS_WIDTH) - 1);

    fifoState_t              state;
    logic [ADDRESS_WIDTH:0]  wrPtr;
    logic [ADDRESS_WIDTH:0]  rdPtr;
    logic [DATA_WIDTH-1:0]   ramData;
    logic                    pushAccept;
    logic                    popAccept;

    // Acceptance uses the registered flags, so a pop never targets an unwritten slot.
    assign pushAccept = push && !full;
    assign popAccept  = pop && !empty;

    // Wrap bits make the pointer difference the exact occupancy 0..DEPTH.
    assign count = wrPtr - rdPtr;

    // Read data is forced to zero whenever no pop result is being presented.
    assign pop_data = pop_valid ? ramData : '0;

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushAccept) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (popAccept) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
        end
    end

    // Pop result strobe, aligned with the registered RAM read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= popAccept;
        end
    end

    // Status FSM with registered full/empty decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= StateEmpty;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            case (state)
                StateEmpty: begin
                    if (pushAccept && !popAccept) begin
                        state <= StatePartial;
                        empty <= 1'b0;
                    end
                end
                StatePartial: begin
                    if (pushAccept && !popAccept && count == LAST_FREE) begin
                        state <= StateFull;
                        full  <= 1'b1;
                    end else if (popAccept && !pushAccept && count == PTR_ONE) begin
                        state <= StateEmpty;
                        empty <= 1'b1;
                    end
                end
                StateFull: begin
                    if (popAccept && !pushAccept) begin
                        state <= StatePartial;
                        full  <= 1'b0;
                    end
                end
                default: begin
                    state <= StateEmpty;
                    empty <= 1'b1;
                    full  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DP_RAM_FIFO_ERR_FLAGS_EN
    // Sticky error flags for rejected requests; cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    // Error flags not built in this configuration.
`endif

    simple_dual_port_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .INDEX_BITS    (INDEX_BITS)
    ) storage (
        .clock         (clock),
        .writeEnable_0 (pushAccept),
        .address_0     (wrPtr[ADDRESS_WIDTH-1:0]),
        .writeData_0   (push_data),
        .writeEnable_1 (1'b0),
        .address_1     (rdPtr[ADDRESS_WIDTH-1:0]),
        .writeData_1   ('0),
        .readData_1    (ramData)
    );

endmodule
